mont_mul: RTL and testbench

- Bit-serial Montgomery modular multiplier: result = a·b·2^-NBITS mod m.
- Consumed by the modular-exponentiation controller, which instantiates two copies: one for the running product, one for squaring.
- Start/done handshake compatible with that controller. Operands are latched at start, so the caller may change its operand registers while a multiply is in flight.
- Operands and result are in the Montgomery domain (R = 2^NBITS).

---
 rtl/mont_pkg.sv | 14 +
 rtl/mont_step.sv | 21 ++
 rtl/mont_mul.sv | 135 +++++++++++++
 tb/tb_mont_mul.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared constants and FSM state type for the Montgomery multiplier family.
package mont_pkg;

  localparam int unsigned WIDTH = 260;
  localparam int unsigned NBITS = 256;
  localparam int unsigned CNT_W = $clog2(NBITS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mont_step.sv
// One radix-2 Montgomery iteration: t_next = (t + a_bit*b + q*m) / 2, q chosen so the sum is even.
module mont_step #(
  parameter int unsigned WIDTH = mont_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] t,
  input  logic             a_bit,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] t_next
);

  logic [WIDTH:0] u;
  logic [WIDTH:0] v;

  always_comb begin
    u      = {1'b0, t} + (a_bit ? {1'b0, b} : '0);
    v      = u + (u[0] ? {1'b0, m} : '0);
    t_next = v[WIDTH:1];
  end

endmodule

// File: rtl/mont_mul.sv
// Bit-serial Montgomery multiplier: result = a*b*2^-NBITS mod m, start/done handshake.
// Optional operand checking (err output) enabled by defining MONT_MUL_CHECK_EN.
module mont_mul
  import mont_pkg::*;
#(
  parameter int unsigned WIDTH = mont_pkg::WIDTH,
  parameter int unsigned NBITS = mont_pkg::NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] result,
`ifdef MONT_MUL_CHECK_EN
  output logic             err,
`endif
  output logic             done
);

  localparam int unsigned CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic [CW-1:0]    i_q, i_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] t_step;

`ifdef MONT_MUL_CHECK_EN
  logic bad_q, bad_d;
  logic err_q, err_d;
`endif

  mont_step #(.WIDTH(WIDTH)) u_step (
    .t      (t_q),
    .a_bit  (a_q[i_q]),
    .b      (b_q),
    .m      (m_q),
    .t_next (t_step)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    t_d      = t_q;
    i_d      = i_q;
    result_d = result_q;
    done_d   = done_q;
`ifdef MONT_MUL_CHECK_EN
    bad_d    = bad_q;
    err_d    = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          m_d     = m;
          t_d     = '0;
          i_d     = '0;
          done_d  = 1'b0;
          state_d = ITER;
`ifdef MONT_MUL_CHECK_EN
          bad_d   = ~m[0] | (a >= m) | (b >= m);
          err_d   = 1'b0;
`endif
        end else begin
          done_d = 1'b1;
        end
      end
      ITER: begin
        t_d = t_step;
        i_d = i_q + 1'b1;
        if (i_q == LAST) state_d = FIX;
      end
      FIX: begin
        result_d = (t_q >= m_q) ? (t_q - m_q) : t_q;
`ifdef MONT_MUL_CHECK_EN
        // Rejected operands still run the full latency so callers see uniform timing.
        if (bad_q) begin
          result_d = '0;
          err_d    = 1'b1;
        end
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      t_q      <= '0;
      i_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
`ifdef MONT_MUL_CHECK_EN
      bad_q    <= 1'b0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      t_q      <= t_d;
      i_q      <= i_d;
      result_q <= result_d;
      done_q   <= done_d;
`ifdef MONT_MUL_CHECK_EN
      bad_q    <= bad_d;
      err_q    <= err_d;
`endif
    end
  end

  assign result = result_q;
  assign done   = done_q;
`ifdef MONT_MUL_CHECK_EN
  assign err    = err_q;
`endif

endmodule

// File: tb/tb_mont_mul.sv
// Directed bench for mont_mul: small m=13 vectors, handshake timing, reset abort, large modulus.
module tb_mont_mul;

  localparam int unsigned W   = 260;
  localparam int unsigned N   = 256;
  localparam int          LAT = N + 2;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a, b, m;
  logic [W-1:0] result;
  logic         done;
`ifdef MONT_MUL_CHECK_EN
  logic         err;
`endif

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  mont_mul #(.WIDTH(W), .NBITS(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .m      (m),
    .result (result),
`ifdef MONT_MUL_CHECK_EN
    .err    (err),
`endif
    .done   (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns #1 after the sampling edge.
  task automatic kick(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic [W-1:0] mi);
    @(negedge clk);
    a = ai; b = bi; m = mi; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Counts edges after the start edge until done rises (bounded); tracks result changes.
  task automatic wait_done(output int lat, output int changes);
    logic [W-1:0] prev;
    prev    = result;
    lat     = 0;
    changes = 0;
    for (int k = 1; k <= LAT + 40; k++) begin
      step();
      if (result !== prev) begin
        changes++;
        prev = result;
      end
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = '0; b = '0; m = '0;
    step();
    step();
    n_vec++;
    if (done !== 1'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_state: done=%b result=%0h, required done=0 result=0", done, result);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_idle_done: done=%b, required 1", done);
    end
  endtask

  task automatic test_small();
    logic [W-1:0] va [4] = '{W'(1), W'(3), W'(1), W'(0)};
    logic [W-1:0] vb [4] = '{W'(1), W'(3), W'(3), W'(7)};
    logic [W-1:0] ve [4] = '{W'(9), W'(3), W'(1), W'(0)};
    int lat, ch;
    for (int unsigned v = 0; v < 4; v++) begin
      kick(va[v], vb[v], W'(13));
      n_vec++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL small%0d_done_low: done=%b, required 0", v, done);
      end
      wait_done(lat, ch);
      n_vec++;
      if (lat != LAT) begin
        n_bad++;
        $display("FAIL small%0d_latency: got %0d, required %0d", v, lat, LAT);
      end
      n_vec++;
      if (result !== ve[v]) begin
        n_bad++;
        $display("FAIL small%0d_result: got %0h, required %0h", v, result, ve[v]);
      end
      n_vec++;
      if (ch > 1) begin
        n_bad++;
        $display("FAIL small%0d_result_updates: got %0d changes, required at most 1", v, ch);
      end
    end
  endtask

  task automatic test_operand_latch();
    int lat, ch;
    kick(W'(3), W'(3), W'(13));
    step();
    a = W'(5); m = W'(11);
    wait_done(lat, ch);
    n_vec++;
    if (lat != LAT - 1 || result !== W'(3)) begin
      n_bad++;
      $display("FAIL operand_latch: lat=%0d result=%0h, required lat=%0d result=3", lat, result, LAT - 1);
    end
  endtask

  task automatic test_ignore_start();
    int lat, ch;
    logic stayed;
    kick(W'(3), W'(3), W'(13));
    for (int k = 1; k < 50; k++) step();
    a = W'(1); b = W'(1); start = 1'b1;
    step();
    start = 1'b0;
    wait_done(lat, ch);
    lat = lat + 50;
    n_vec++;
    if (lat != LAT || result !== W'(3)) begin
      n_bad++;
      $display("FAIL ignore_start: lat=%0d result=%0h, required lat=%0d result=3", lat, result, LAT);
    end
    stayed = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (done !== 1'b1) stayed = 1'b0;
    end
    n_vec++;
    if (stayed !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore_start_no_rerun: done dropped after completion, required steady 1");
    end
  endtask

  task automatic test_reset_mid();
    int lat, ch;
    kick(W'(1), W'(3), W'(13));
    for (int k = 1; k < 100; k++) step();
    reset = 1'b1;
    step();
    n_vec++;
    if (done !== 1'b0 || result !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_abort: done=%b result=%0h, required done=0 result=0", done, result);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid_idle: done=%b, required 1", done);
    end
    kick(W'(1), W'(1), W'(13));
    wait_done(lat, ch);
    n_vec++;
    if (lat != LAT || result !== W'(9)) begin
      n_bad++;
      $display("FAIL reset_mid_fresh: lat=%0d result=%0h, required lat=%0d result=9", lat, result, LAT);
    end
  endtask

  // Large modulus: accept result iff result < p and result*2^256 == a*b (mod p).
  task automatic test_large();
    logic [W-1:0]   p, ra, rb;
    logic [255:0]   r;
    logic [519:0]   pw, lhs, rhs;
    int lat, ch;
    p = '0;
    p[255] = 1'b1;
    p = p - W'(19);
    pw = 520'(p);
    for (int unsigned v = 0; v < 100; v++) begin
      for (int unsigned j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
      ra = W'(520'(r) % pw);
      for (int unsigned j = 0; j < 8; j++) r[j*32 +: 32] = $urandom;
      rb = W'(520'(r) % pw);
      if (v == 0) ra = p - W'(1);
      if (v == 1) begin ra = p - W'(1); rb = p - W'(1); end
      kick(ra, rb, p);
      wait_done(lat, ch);
      lhs = (520'(result) << 256) % pw;
      rhs = (520'(ra) * 520'(rb)) % pw;
      n_vec++;
      if (lat != LAT || result >= p || lhs !== rhs) begin
        n_bad++;
        $display("FAIL large%0d: lat=%0d result=%0h, required lat=%0d and result*R mod p = %0h",
                 v, lat, result, LAT, rhs);
      end
    end
  endtask

`ifdef MONT_MUL_CHECK_EN
  task automatic test_check();
    int lat, ch;
    kick(W'(3), W'(3), W'(14));
    wait_done(lat, ch);
    n_vec++;
    if (lat != LAT || result !== '0 || err !== 1'b1) begin
      n_bad++;
      $display("FAIL check_even_m: lat=%0d result=%0h err=%b, required lat=%0d result=0 err=1",
               lat, result, err, LAT);
    end
    kick(W'(1), W'(1), W'(13));
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL check_err_clear: err=%b, required 0", err);
    end
    wait_done(lat, ch);
    n_vec++;
    if (result !== W'(9) || err !== 1'b0) begin
      n_bad++;
      $display("FAIL check_valid_after: result=%0h err=%b, required result=9 err=0", result, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_small();
    test_operand_latch();
    test_ignore_start();
    test_reset_mid();
    test_large();
`ifdef MONT_MUL_CHECK_EN
    test_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
